ps2_key_event: RTL and testbench
================================

Name: ps2_key_event

Overview:
- Sits between `ps2_keyboard` (raw scan-code byte FIFO) and the text-editor/cursor logic.
- Pops raw Set-2 bytes using the `ready`/`nextdata_n` handshake and folds E0/F0/E1 prefixes into single key events.
- Tracks modifier and Caps Lock state and flags typematic repeats.
- Queues finished events in a small FIFO, so the editor sees one clean event per keystroke.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- REPEAT_EN, 1, 1 = queue typematic repeats with ev_repeat=1; 0 = drop them.

Ports:
- clk  in  1  system clock (clk_50m domain).
- clrn  in  1  asynchronous active-low reset.
- kb_data  in  8  byte from ps2_keyboard.
- kb_ready  in  1  ps2_keyboard FIFO non-empty.
- nextdata_n  out  1  one-cycle low pulse pops ps2_keyboard.
- ev_valid  out  1  event FIFO non-empty.
- ev_data  out  13  head event {caps, shift, repeat, brk, ext, code[7:0]}.
- ev_pop  in  1  consumer pulse; removes head when ev_valid=1.
- mod_shift  out  1  live Shift state.
- mod_ctrl  out  1  live Ctrl state.
- mod_alt  out  1  live Alt state.
- caps_lock  out  1  live Caps Lock state.
- overflow  out  1  sticky: event dropped because the FIFO was full.

Behaviour:
- Interface: clk is the single clock; clrn is asynchronous and active-low.
- Reset (clrn=0, async): nextdata_n=1, parser state IDLE, pause counter 0, FIFO empty (ev_valid=0, ev_data=0), all mods 0, caps_lock 0, overflow 0, last_make cleared. Any partial prefix sequence is discarded.
- Consume cycle: kb_ready=1 and registered nextdata_n=1.
  - kb_data is sampled and nextdata_n is driven 0 for exactly the next cycle, then 1.
  - Peak throughput is one byte per 2 cycles.
  - The block never stalls ps2_keyboard, even when its own FIFO is full.
- Parser FSM (states IDLE, EXT, BRK, EXT_BRK, PAUSE):
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → PAUSE with counter=7.
    - 00, FF, AA, FA, FE, EE → dropped, stay IDLE.
    - Any other byte → emit {ext=0, brk=0}.
  - EXT: F0 → EXT_BRK; E0 → stay EXT; other byte → emit {ext=1, brk=0}, go IDLE.
  - BRK: emit {ext=0, brk=1}, go IDLE.
  - EXT_BRK: emit {ext=1, brk=1}, go IDLE.
  - PAUSE: decrement the counter on each byte. When it reaches 0, emit one make {ext=1, code=8'h77}; no break event is generated; go IDLE.
- Repeat detection:
  - last_make holds {ext, code} of the last make.
  - A make equal to last_make is a repeat: ev_repeat=1, or dropped if REPEAT_EN=0.
  - A break matching last_make clears it.
  - A make of a different key replaces it.
- Modifiers, updated in the same cycle the event is emitted:
  - shift = L(12) OR R(59), each tracked separately.
  - ctrl = code 14, any ext.
  - alt = code 11, any ext.
  - caps_lock toggles on a non-repeat make of 58; a break of 58 has no effect.
  - The snapshot in ev_data[12:11] is the post-update value.
  - Modifiers update even if the event is dropped for FIFO full.
- Latency: event written at the end of the consume cycle of its final byte; ev_valid/ev_data valid the following cycle.
- FIFO:
  - ev_data is the head, combinational from storage; show-ahead.
  - Push when full: accepted only if ev_pop=1 with ev_valid=1 in the same cycle; otherwise dropped and overflow set (sticky until clrn).
  - Pop when empty: ignored.
  - Push+pop when empty: push accepted, pop ignored.
  - Pointers wrap modulo FIFO_DEPTH; a separate count or extra pointer bit distinguishes full from empty.

Decomposition:
- Shared include file ps2_defs.vh holds:
  - Prefix constants: KC_EXT=8'hE0, KC_BRK=8'hF0, KC_PAUSE=8'hE1.
  - Key constants: KC_LSHIFT=8'h12, KC_RSHIFT=8'h59, KC_CTRL=8'h14, KC_ALT=8'h11, KC_CAPS=8'h58.
  - Drop-list codes.
  - ev_data field indices: EV_CODE 7:0, EV_EXT 8, EV_BRK 9, EV_REP 10, EV_SHIFT 11, EV_CAPS 12.
- One sub-module: ps2_event_fifo, a generic synchronous show-ahead FIFO parameterised on width and depth, with push/pop/full/empty.

Test Plan:
- Bytes 1C, F0, 1C → two events: 13'h001C, then 13'h021C. ev_valid rises 1 cycle after the final 1C consume. nextdata_n pulses exactly once per byte.
- Bytes 12, 1C, F0, 1C, F0, 12 → mod_shift=1 after the first byte; the 1C events carry shift=1; mod_shift=0 after the final 12.
- Bytes E0, 75, E0, F0, 75 → events 13'h0175 and 13'h0375.
- Bytes 58, F0, 58, 58 → caps_lock 0→1→1→0. 1C then gives ev_data[12]=0. With REPEAT_EN=1, 1C, 1C, 1C gives ev_repeat=0, 1, 1.
- FIFO_DEPTH=4, ev_pop held 0, 6 distinct makes → ev_valid=1 holding the first four, overflow=1. Then 4 pops drain in order and ev_valid=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event 13'h0177; mod_ctrl remains 0. Assert clrn=0 after E0 mid-sequence; 1C after release → 13'h001C with ext=0.

Source files
------------

// File: rtl/ps2_key_event_pkg.sv
// Shared scan-code constants, ev_data field layout and parser state type
// for the PS/2 key-event decoder.
package ps2_key_event_pkg;

  localparam logic [7:0] KC_EXT    = 8'hE0;
  localparam logic [7:0] KC_BRK    = 8'hF0;
  localparam logic [7:0] KC_PAUSE  = 8'hE1;
  localparam logic [7:0] KC_LSHIFT = 8'h12;
  localparam logic [7:0] KC_RSHIFT = 8'h59;
  localparam logic [7:0] KC_CTRL   = 8'h14;
  localparam logic [7:0] KC_ALT    = 8'h11;
  localparam logic [7:0] KC_CAPS   = 8'h58;
  localparam logic [7:0] KC_PAUSE_KEY = 8'h77;

  localparam int unsigned EV_W     = 13;
  localparam int unsigned EV_EXT   = 8;
  localparam int unsigned EV_BRK   = 9;
  localparam int unsigned EV_REP   = 10;
  localparam int unsigned EV_SHIFT = 11;
  localparam int unsigned EV_CAPS  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } parse_state_t;

  // Keyboard status/acknowledge bytes that never form part of a key event.
  function automatic logic is_drop_code(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous show-ahead FIFO; head is the oldest entry, combinational
// from storage. A push into a full FIFO succeeds only alongside a real pop.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// Folds raw PS/2 Set-2 bytes into single key events with modifier snapshot,
// repeat flag and Caps Lock tracking, queued for the editor in a small FIFO.
module ps2_key_event
  import ps2_key_event_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REPEAT_EN  = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  kb_data,
  input  logic        kb_ready,
  output logic        nextdata_n,
  output logic        ev_valid,
  output logic [12:0] ev_data,
  input  logic        ev_pop,
  output logic        mod_shift,
  output logic        mod_ctrl,
  output logic        mod_alt,
  output logic        caps_lock,
  output logic        overflow
);

  parse_state_t state, state_nxt;
  logic [2:0]   pause_cnt, pause_cnt_nxt;
  logic         lshift, rshift;
  logic         lshift_nxt, rshift_nxt, ctrl_nxt, alt_nxt, caps_nxt;
  logic         last_valid;
  logic [8:0]   last_key;
  logic         consume;
  logic         emit, e_ext, e_brk;
  logic [7:0]   e_code;
  logic [8:0]   key;
  logic         is_rep;
  logic         push;
  logic [EV_W-1:0] ev_word;
  logic         fifo_full, fifo_empty;

  assign consume   = kb_ready && nextdata_n;
  assign mod_shift = lshift || rshift;
  assign ev_valid  = !fifo_empty;

  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    emit          = 1'b0;
    e_ext         = 1'b0;
    e_brk         = 1'b0;
    e_code        = kb_data;
    if (consume) begin
      case (state)
        ST_IDLE: begin
          if (kb_data == KC_EXT) begin
            state_nxt = ST_EXT;
          end else if (kb_data == KC_BRK) begin
            state_nxt = ST_BRK;
          end else if (kb_data == KC_PAUSE) begin
            state_nxt     = ST_PAUSE;
            pause_cnt_nxt = 3'd7;
          end else if (!is_drop_code(kb_data)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (kb_data == KC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (kb_data != KC_EXT) begin
            emit      = 1'b1;
            e_ext     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit      = 1'b1;
          e_brk     = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          emit      = 1'b1;
          e_ext     = 1'b1;
          e_brk     = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_PAUSE: begin
          // The 7 bytes after E1 carry no usable info; only the last one yields the make.
          pause_cnt_nxt = pause_cnt - 3'd1;
          if (pause_cnt <= 3'd1) begin
            pause_cnt_nxt = '0;
            emit          = 1'b1;
            e_ext         = 1'b1;
            e_code        = KC_PAUSE_KEY;
            state_nxt     = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key        = {e_ext, e_code};
    is_rep     = emit && !e_brk && last_valid && (last_key == key);
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    ctrl_nxt   = mod_ctrl;
    alt_nxt    = mod_alt;
    caps_nxt   = caps_lock;
    if (emit) begin
      if (!e_ext && e_code == KC_LSHIFT) lshift_nxt = !e_brk;
      if (!e_ext && e_code == KC_RSHIFT) rshift_nxt = !e_brk;
      if (e_code == KC_CTRL)             ctrl_nxt   = !e_brk;
      if (e_code == KC_ALT)              alt_nxt    = !e_brk;
      if (!e_brk && !is_rep && e_code == KC_CAPS) caps_nxt = !caps_lock;
    end
    push               = emit && !(is_rep && (REPEAT_EN == 0));
    ev_word            = '0;
    ev_word[7:0]       = e_code;
    ev_word[EV_EXT]    = e_ext;
    ev_word[EV_BRK]    = e_brk;
    ev_word[EV_REP]    = is_rep;
    ev_word[EV_SHIFT]  = lshift_nxt || rshift_nxt;
    ev_word[EV_CAPS]   = caps_nxt;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      pause_cnt  <= '0;
      nextdata_n <= 1'b1;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      mod_ctrl   <= 1'b0;
      mod_alt    <= 1'b0;
      caps_lock  <= 1'b0;
      last_valid <= 1'b0;
      last_key   <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pause_cnt  <= pause_cnt_nxt;
      nextdata_n <= !consume;
      lshift     <= lshift_nxt;
      rshift     <= rshift_nxt;
      mod_ctrl   <= ctrl_nxt;
      mod_alt    <= alt_nxt;
      caps_lock  <= caps_nxt;
      if (emit) begin
        if (!e_brk) begin
          last_valid <= 1'b1;
          last_key   <= key;
        end else if (last_valid && last_key == key) begin
          last_valid <= 1'b0;
        end
      end
      if (push && fifo_full && !(ev_pop && !fifo_empty)) begin
        overflow <= 1'b1;
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (push),
    .push_data (ev_word),
    .pop       (ev_pop),
    .head      (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: byte table with expected events/modifiers,
// plus sequences for latency, FIFO full/overflow, Pause and mid-sequence reset.
module tb_ps2_key_event;

  logic        clk = 1'b0;
  logic        clrn;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        nextdata_n;
  logic        ev_valid;
  logic [12:0] ev_data;
  logic        ev_pop;
  logic        mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;

  int tests = 0;
  int fails = 0;
  int bytes_sent = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  ps2_key_event #(
    .FIFO_DEPTH (4),
    .REPEAT_EN  (1)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .nextdata_n (nextdata_n),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_pop     (ev_pop),
    .mod_shift  (mod_shift),
    .mod_ctrl   (mod_ctrl),
    .mod_alt    (mod_alt),
    .caps_lock  (caps_lock),
    .overflow   (overflow)
  );

  always @(negedge clk) if (clrn && !nextdata_n) pulses++;

  typedef struct packed {
    logic [7:0]  b;
    logic        has_ev;
    logic [12:0] ev;
    logic [3:0]  mods;   // {shift, ctrl, alt, caps}
  } vec_t;

  vec_t vecs [0:42];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    kb_data  = b;
    kb_ready = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0;
    @(negedge clk);
    bytes_sent++;
  endtask

  task automatic pop_ev();
    ev_pop = 1'b1;
    @(negedge clk);
    ev_pop = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b1, 13'h001C, 4'b0000};
    vecs[1]  = '{8'hF0, 1'b0, 13'h0000, 4'b0000};
    vecs[2]  = '{8'h1C, 1'b1, 13'h021C, 4'b0000};
    vecs[3]  = '{8'h12, 1'b1, 13'h0812, 4'b1000};
    vecs[4]  = '{8'h1C, 1'b1, 13'h081C, 4'b1000};
    vecs[5]  = '{8'hF0, 1'b0, 13'h0000, 4'b1000};
    vecs[6]  = '{8'h1C, 1'b1, 13'h0A1C, 4'b1000};
    vecs[7]  = '{8'hF0, 1'b0, 13'h0000, 4'b1000};
    vecs[8]  = '{8'h12, 1'b1, 13'h0212, 4'b0000};
    vecs[9]  = '{8'hE0, 1'b0, 13'h0000, 4'b0000};
    vecs[10] = '{8'h75, 1'b1, 13'h0175, 4'b0000};
    vecs[11] = '{8'hE0, 1'b0, 13'h0000, 4'b0000};
    vecs[12] = '{8'hF0, 1'b0, 13'h0000, 4'b0000};
    vecs[13] = '{8'h75, 1'b1, 13'h0375, 4'b0000};
    vecs[14] = '{8'h58, 1'b1, 13'h1058, 4'b0001};
    vecs[15] = '{8'hF0, 1'b0, 13'h0000, 4'b0001};
    vecs[16] = '{8'h58, 1'b1, 13'h1258, 4'b0001};
    vecs[17] = '{8'h58, 1'b1, 13'h0058, 4'b0000};
    vecs[18] = '{8'h1C, 1'b1, 13'h001C, 4'b0000};
    vecs[19] = '{8'h1C, 1'b1, 13'h041C, 4'b0000};
    vecs[20] = '{8'h1C, 1'b1, 13'h041C, 4'b0000};
    vecs[21] = '{8'hFA, 1'b0, 13'h0000, 4'b0000};
    vecs[22] = '{8'h14, 1'b1, 13'h0014, 4'b0100};
    vecs[23] = '{8'hF0, 1'b0, 13'h0000, 4'b0100};
    vecs[24] = '{8'h14, 1'b1, 13'h0214, 4'b0000};
    vecs[25] = '{8'h11, 1'b1, 13'h0011, 4'b0010};
    vecs[26] = '{8'hF0, 1'b0, 13'h0000, 4'b0010};
    vecs[27] = '{8'h11, 1'b1, 13'h0211, 4'b0000};
    vecs[28] = '{8'hE0, 1'b0, 13'h0000, 4'b0000};
    vecs[29] = '{8'h14, 1'b1, 13'h0114, 4'b0100};
    vecs[30] = '{8'hE0, 1'b0, 13'h0000, 4'b0100};
    vecs[31] = '{8'hF0, 1'b0, 13'h0000, 4'b0100};
    vecs[32] = '{8'h14, 1'b1, 13'h0314, 4'b0000};
    vecs[33] = '{8'h59, 1'b1, 13'h0859, 4'b1000};
    vecs[34] = '{8'h12, 1'b1, 13'h0812, 4'b1000};
    vecs[35] = '{8'hF0, 1'b0, 13'h0000, 4'b1000};
    vecs[36] = '{8'h59, 1'b1, 13'h0A59, 4'b1000};
    vecs[37] = '{8'hF0, 1'b0, 13'h0000, 4'b1000};
    vecs[38] = '{8'h12, 1'b1, 13'h0212, 4'b0000};
    vecs[39] = '{8'hE0, 1'b0, 13'h0000, 4'b0000};
    vecs[40] = '{8'hE0, 1'b0, 13'h0000, 4'b0000};
    vecs[41] = '{8'h1C, 1'b1, 13'h011C, 4'b0000};
    vecs[42] = '{8'h1C, 1'b1, 13'h001C, 4'b0000};

    clrn = 1'b0; kb_data = '0; kb_ready = 1'b0; ev_pop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", 13'(nextdata_n), 13'd1);
    check("rst_ev_valid", 13'(ev_valid), 13'd0);
    check("rst_ev_data", ev_data, 13'h0000);
    check("rst_overflow", 13'(overflow), 13'd0);
    check("rst_mods", 13'({mod_shift, mod_ctrl, mod_alt, caps_lock}), 13'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Latency and handshake of a single break event
    send_byte(8'hF0);
    check("lat_pre_valid", 13'(ev_valid), 13'd0);
    kb_data = 8'h1C; kb_ready = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0;
    check("lat_valid", 13'(ev_valid), 13'd1);
    check("lat_nextdata_low", 13'(nextdata_n), 13'd0);
    @(negedge clk);
    bytes_sent++;
    check("lat_nextdata_high", 13'(nextdata_n), 13'd1);
    check("lat_data", ev_data, 13'h021C);
    pop_ev();

    for (int i = 0; i < 43; i++) begin
      send_byte(vecs[i].b);
      if (vecs[i].has_ev) begin
        check($sformatf("vec%0d_valid", i), 13'(ev_valid), 13'd1);
        check($sformatf("vec%0d_data", i), ev_data, vecs[i].ev);
        pop_ev();
      end else begin
        check($sformatf("vec%0d_novalid", i), 13'(ev_valid), 13'd0);
      end
      check($sformatf("vec%0d_mods", i), 13'({mod_shift, mod_ctrl, mod_alt, caps_lock}),
            13'(vecs[i].mods));
    end

    // Fill, push with simultaneous pop while full, then overflow
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    kb_data = 8'h2C; kb_ready = 1'b1; ev_pop = 1'b1;
    @(negedge clk);
    kb_ready = 1'b0; ev_pop = 1'b0;
    @(negedge clk);
    bytes_sent++;
    check("full_pushpop_ovf", 13'(overflow), 13'd0);
    send_byte(8'h35);
    check("ovf_set", 13'(overflow), 13'd1);
    check("ovf_valid", 13'(ev_valid), 13'd1);
    check("drain0", ev_data, 13'h001D); pop_ev();
    check("drain1", ev_data, 13'h0024); pop_ev();
    check("drain2", ev_data, 13'h002D); pop_ev();
    check("drain3", ev_data, 13'h002C); pop_ev();
    check("drain_empty", 13'(ev_valid), 13'd0);
    pop_ev();
    check("pop_empty_ignored", 13'(ev_valid), 13'd0);
    check("ovf_sticky", 13'(overflow), 13'd1);

    // Pause sequence yields a single extended make
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
    check("pause_none_yet", 13'(ev_valid), 13'd0);
    send_byte(8'h77);
    check("pause_valid", 13'(ev_valid), 13'd1);
    check("pause_data", ev_data, 13'h0177);
    check("pause_ctrl", 13'(mod_ctrl), 13'd0);
    pop_ev();
    check("pause_single", 13'(ev_valid), 13'd0);

    // Reset in the middle of an E0 prefix
    send_byte(8'h12);
    check("pre_rst_shift_ev", ev_data, 13'h0812);
    pop_ev();
    send_byte(8'hE0);
    clrn = 1'b0;
    #1;
    check("mid_rst_overflow", 13'(overflow), 13'd0);
    check("mid_rst_shift", 13'(mod_shift), 13'd0);
    check("mid_rst_valid", 13'(ev_valid), 13'd0);
    check("mid_rst_nextdata_n", 13'(nextdata_n), 13'd1);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    send_byte(8'h1C);
    check("post_rst_valid", 13'(ev_valid), 13'd1);
    check("post_rst_data", ev_data, 13'h001C);
    pop_ev();

    check("nextdata_pulses", 13'(pulses), 13'(bytes_sent));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
